// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Two-master arbiter in front of one port of a dual-port RAM with a 1-cycle
//   registered read. Master 0 is the CPU load/store path. Master 1 is a
//   secondary agent such as DMA, a loader or a video fetch unit.
//   The RAM picks its output bank from the *live* address MSB. While a read
//   response is on ram_q, the address bus must therefore stay in the bank of
//   that read.
//
//   Ports:
//     clk, reset           clock, synchronous active-high reset
//     mN_req/we/addr/wdata master N request (held until mN_gnt)
//     mN_gnt               combinational accept strobe
//     mN_rvalid/rdata      read response, exactly one cycle after accept
//     ram_addr/data/we     drive to the RAM port
//     ram_q                registered read data from the RAM
//
//   Build option:
//     ARB_ROUND_ROBIN_EN   defined  : round-robin on contention (last_grant)
//                          undefined: fixed priority, master 0 wins
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int MSB = ADDR_WIDTH - 1;

  logic [ADDR_WIDTH-1:0] held_addr;   // address of last accepted access
  logic                  rd_pend;     // a read response is on ram_q this cycle
  logic                  haz0, haz1;
  logic                  elig0, elig1;

`ifdef ARB_ROUND_ROBIN_EN
  logic                  last_grant;  // 0 = M0, 1 = M1
`endif

  // The rvalid registers double as the pending-read flag.
  assign rd_pend = m0_rvalid | m1_rvalid;

  // A request that would move the live bank away from the in-flight read
  // would corrupt its data, so it is held off for a cycle.
  assign haz0  = rd_pend & (m0_addr[MSB] != held_addr[MSB]);
  assign haz1  = rd_pend & (m1_addr[MSB] != held_addr[MSB]);
  assign elig0 = m0_req & ~haz0 & ~reset;
  assign elig1 = m1_req & ~haz1 & ~reset;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention, the master that did not win last time wins now. A
  // hazard-stalled master is not eligible, so it does not update last_grant
  // and keeps its turn.
  assign m0_gnt = elig0 & (~elig1 | last_grant);
  assign m1_gnt = elig1 & (~elig0 | ~last_grant);
`else
  assign m0_gnt = elig0;
  assign m1_gnt = elig1 & ~elig0;
`endif

  // RAM drive. When idle, hold the last address so the bank select stays on
  // the bank of any outstanding read.
  always_comb begin
    ram_addr = held_addr;
    ram_data = '0;
    ram_we   = 1'b0;
    if (m0_gnt) begin
      ram_addr = m0_addr;
      ram_data = m0_wdata;
      ram_we   = m0_we;
    end else if (m1_gnt) begin
      ram_addr = m1_addr;
      ram_data = m1_wdata;
      ram_we   = m1_we;
    end
  end

  assign m0_rdata = m0_rvalid ? ram_q : '0;
  assign m1_rdata = m1_rvalid ? ram_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      held_addr  <= '0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt | m1_gnt)
        held_addr <= ram_addr;
`ifdef ARB_ROUND_ROBIN_EN
      if (m0_gnt)
        last_grant <= 1'b0;
      else if (m1_gnt)
        last_grant <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Directed scenarios followed by randomized two-master traffic. The
//   reference is a transaction-level model: a shadow memory, the pending-read
//   record and the arbitration rules. A banked RAM model drives ram_q, with
//   the output bank picked from the live address MSB.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, we;
  logic [9:0]  addr [2];
  logic [15:0] wdata [2];
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_we;
  logic [15:0] m0_rdata, m1_rdata, ram_data, ram_q;
  logic [9:0]  ram_addr;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  // Banked RAM: each bank registers its own read; the output mux follows the
  // live address MSB.
  logic [15:0] mem [1024];
  logic [15:0] q_lo, q_hi;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    q_lo <= mem[{1'b0, ram_addr[8:0]}];
    q_hi <= mem[{1'b1, ram_addr[8:0]}];
  end
  assign ram_q = ram_addr[9] ? q_hi : q_lo;

  // Reference state
  logic [15:0] ref_mem [1024];
  bit          pend;
  int          pm;
  logic [15:0] pdata;
  logic [9:0]  held;
  int          last_g;

  int n_vec = 0, n_err = 0;
  logic        obs_g0, obs_g1, obs_rv0, obs_rv1;
  logic [15:0] obs_rd0, obs_rd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic preload(input int a, input logic [15:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // One clock cycle. Inputs are already set; check the DUT against the
  // model, then advance the model past the rising edge.
  task automatic step(input bit en);
    bit h0, h1, e0, e1;
    int w;
    logic [9:0]  ea;
    logic [15:0] ed;
    logic        ew;
    #1;
    h0 = pend && (addr[0][9] != held[9]);
    h1 = pend && (addr[1][9] != held[9]);
    e0 = req[0] && !h0 && !reset;
    e1 = req[1] && !h1 && !reset;
    w = -1;
`ifdef ARB_ROUND_ROBIN_EN
    if (e0 && e1) w = (last_g == 1) ? 0 : 1;
    else if (e0)  w = 0;
    else if (e1)  w = 1;
`else
    if (e0)      w = 0;
    else if (e1) w = 1;
`endif
    ea = held; ed = 16'h0; ew = 1'b0;
    if (w >= 0) begin ea = addr[w]; ed = wdata[w]; ew = we[w]; end
    obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid;
    obs_rd0 = m0_rdata; obs_rd1 = m1_rdata;
    if (en) begin
      chk("m0_gnt",    32'(m0_gnt),    32'(w == 0));
      chk("m1_gnt",    32'(m1_gnt),    32'(w == 1));
      chk("ram_we",    32'(ram_we),    32'(ew));
      chk("ram_addr",  32'(ram_addr),  32'(ea));
      chk("ram_data",  32'(ram_data),  32'(ed));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(pend && pm == 0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(pend && pm == 1));
      chk("m0_rdata",  32'(m0_rdata),  32'((pend && pm == 0) ? pdata : 16'h0));
      chk("m1_rdata",  32'(m1_rdata),  32'((pend && pm == 1) ? pdata : 16'h0));
    end
    @(posedge clk);
    @(negedge clk);
    if (reset) begin
      pend = 0; held = '0; last_g = 1;
    end else begin
      pend = 0;
      if (w >= 0) begin
        held = addr[w];
        last_g = w;
        if (we[w]) ref_mem[addr[w]] = wdata[w];
        else begin pend = 1; pm = w; pdata = ref_mem[addr[w]]; end
        req[w] = 1'b0;
      end
    end
  endtask

  task automatic issue(input int m, input bit w_en, input logic [9:0] a, input logic [15:0] d);
    req[m] = 1'b1; we[m] = w_en; addr[m] = a; wdata[m] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(1); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; we = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    pend = 0; pm = 0; pdata = '0; held = '0; last_g = 1;
    for (int i = 0; i < 1024; i++) preload(i, 16'($urandom));
    preload(10'h005, 16'hBEEF);
    preload(10'h001, 16'h00A1);
    preload(10'h002, 16'h00A2);
    preload(10'h003, 16'h00A3);
    preload(10'h010, 16'h1111);
    preload(10'h210, 16'h5A5A);
    step(0);            // DUT state unknown before the first reset edge
    step(1);
    reset = 1'b0;

    // Single read after reset
    issue(0, 0, 10'h005, 16'h0);
    step(1); chk("tp1_gnt", 32'(obs_g0), 32'd1);
    step(1); chk("tp1_rvalid", 32'(obs_rv0), 32'd1);
             chk("tp1_rdata", 32'(obs_rd0), 32'hBEEF);
             chk("tp1_m1_rvalid", 32'(obs_rv1), 32'd0);

    // Contention from reset
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    issue(0, 0, 10'h001, 16'h0); issue(1, 0, 10'h002, 16'h0);
    step(1); chk("tp2_c0_g0", 32'(obs_g0), 32'd1); chk("tp2_c0_g1", 32'(obs_g1), 32'd0);
    step(1); chk("tp2_c1_g1", 32'(obs_g1), 32'd1); chk("tp2_c1_rd0", 32'(obs_rd0), 32'h00A1);
    step(1); chk("tp2_c2_rv1", 32'(obs_rv1), 32'd1); chk("tp2_c2_rd1", 32'(obs_rd1), 32'h00A2);
`else
    issue(1, 0, 10'h002, 16'h0);
    for (int k = 0; k < 3; k++) begin
      issue(0, 0, 10'h001, 16'h0);
      step(1); chk("tp2_fp_g0", 32'(obs_g0), 32'd1); chk("tp2_fp_g1", 32'(obs_g1), 32'd0);
    end
    step(1); chk("tp2_fp_c3_g1", 32'(obs_g1), 32'd1);
    step(1); chk("tp2_fp_rd1", 32'(obs_rd1), 32'h00A2);
`endif

    // Bank hazard bubble
    issue(0, 0, 10'h010, 16'h0);
    step(1); chk("tp3_g0", 32'(obs_g0), 32'd1);
    issue(1, 0, 10'h210, 16'h0);
    step(1); chk("tp3_stall_g1", 32'(obs_g1), 32'd0); chk("tp3_rd0", 32'(obs_rd0), 32'h1111);
    step(1); chk("tp3_g1", 32'(obs_g1), 32'd1);
    step(1); chk("tp3_rd1", 32'(obs_rd1), 32'h5A5A);

    // Read after write
    issue(1, 1, 10'h3FF, 16'h1234);
    step(1); chk("tp4_wr_gnt", 32'(obs_g1), 32'd1);
    issue(0, 0, 10'h3FF, 16'h0);
    step(1); chk("tp4_rd_gnt", 32'(obs_g0), 32'd1); chk("tp4_no_wr_rv", 32'(obs_rv1), 32'd0);
    step(1); chk("tp4_rdata", 32'(obs_rd0), 32'h1234);

    // Back-to-back same-bank reads
    for (int i = 1; i <= 4; i++) begin
      if (i <= 3) issue(0, 0, 10'(i), 16'h0);
      step(1);
      if (i <= 3) chk("tp5_gnt", 32'(obs_g0), 32'd1);
      if (i >= 2) chk("tp5_rdata", 32'(obs_rd0), 32'h00A0 + 32'(i - 1));
    end

    // Reset with a read in flight
    issue(0, 0, 10'h005, 16'h0);
    step(1);
    reset = 1'b1; issue(1, 0, 10'h007, 16'h0);
    step(1); chk("tp6_gnt_in_reset", 32'(obs_g1), 32'd0);
    reset = 1'b0; req = '0;
    step(1); chk("tp6_rvalid", 32'(obs_rv0), 32'd0); chk("tp6_rdata", 32'(obs_rd0), 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++)
        if (!req[m] && $urandom_range(0, 99) < 60)
          issue(m, $urandom_range(0, 3) == 0,
                {1'($urandom_range(0, 1)), 6'd0, 3'($urandom_range(0, 7))},
                16'($urandom));
      reset = ($urandom_range(0, 199) == 0);
      step(1);
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
